// File: rtl/pip_stage_skid.sv
// Two-entry skid pipeline stage with registered valid/ready, flush of control
// bits, and saturating bubble/flush statistics counters.
module pip_stage_skid #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 12,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [CTRL_WIDTH-1:0] ctrl_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  flush_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [CTRL_WIDTH-1:0] ctrl_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [1:0]            occupancy_o,
   output logic [CNT_WIDTH-1:0]  bubble_cnt_o,
   output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  valid_q, valid_d;
   logic                  ready_q, ready_d;
   logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
   logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
   logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;
   logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

   logic in_fire;
   logic out_fire;

   assign in_fire  = valid_i && ready_q;
   assign out_fire = valid_q && ready_i;

   always_comb begin
      state_d      = state_q;
      main_ctrl_d  = main_ctrl_q;
      main_data_d  = main_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;

      if (flush_i) begin
         // Payload stays on data_o; only control is killed.
         state_d     = EMPTY;
         main_ctrl_d = '0;
         if (state_q != EMPTY && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
      end else begin
         if (!valid_q && ready_i && bubble_cnt_q != '1)
            bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);

         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_ctrl_d = ctrl_i;
                  main_data_d = data_i;
                  state_d     = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_ctrl_d = ctrl_i;
                  main_data_d = data_i;
               end else if (in_fire) begin
                  skid_ctrl_d = ctrl_i;
                  skid_data_d = data_i;
                  state_d     = TWO;
               end else if (out_fire) begin
                  main_ctrl_d = '0;
                  state_d     = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
                  state_d     = ONE;
               end
            end
            default: begin
               main_ctrl_d = '0;
               state_d     = EMPTY;
            end
         endcase
      end

      valid_d = (state_d != EMPTY);
      ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= EMPTY;
         valid_q      <= 1'b0;
         ready_q      <= 1'b1;
         main_ctrl_q  <= '0;
         main_data_q  <= '0;
         skid_ctrl_q  <= '0;
         skid_data_q  <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         ready_q      <= ready_d;
         main_ctrl_q  <= main_ctrl_d;
         main_data_q  <= main_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_data_q  <= skid_data_d;
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign valid_o      = valid_q;
   assign ready_o      = ready_q;
   assign ctrl_o       = main_ctrl_q;
   assign data_o       = main_data_q;
   assign occupancy_o  = state_q;
   assign bubble_cnt_o = bubble_cnt_q;
   assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pip_stage_skid.sv
// Bench for pip_stage_skid: directed scenarios plus a randomized run
// against a queue-based model of the stage.
module tb_pip_stage_skid;

   localparam int DW   = 32;
   localparam int CW   = 12;
   localparam int NW   = 4;
   localparam int CMAX = (1 << NW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_i;
   logic          ready_o;
   logic [CW-1:0] ctrl_i;
   logic [DW-1:0] data_i;
   logic          flush;
   logic          valid_o;
   logic          ready_i;
   logic [CW-1:0] ctrl_o;
   logic [DW-1:0] data_o;
   logic [1:0]    occ;
   logic [NW-1:0] bub_cnt;
   logic [NW-1:0] fl_cnt;

   always #5 clk = ~clk;

   pip_stage_skid #(
      .DATA_WIDTH(DW),
      .CTRL_WIDTH(CW),
      .CNT_WIDTH (NW)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .ctrl_i      (ctrl_i),
      .data_i      (data_i),
      .flush_i     (flush),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .ctrl_o      (ctrl_o),
      .data_o      (data_o),
      .occupancy_o (occ),
      .bubble_cnt_o(bub_cnt),
      .flush_cnt_o (fl_cnt)
   );

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   logic [DW-1:0] m_shown;
   int            m_bub;
   int            m_fl;
   int            checks;
   int            failures;

   // Advance one clock edge and update the model with the inputs that were
   // stable at that edge; returns 1 ns after the edge.
   task automatic step();
      bit in_ok;
      bit out_ok;
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_shown = '0;
         m_bub   = 0;
         m_fl    = 0;
      end else if (flush) begin
         if (mq.size() > 0 && m_fl < CMAX) m_fl++;
         mq.delete();
      end else begin
         in_ok  = valid_i && (mq.size() < 2);
         out_ok = (mq.size() > 0) && ready_i;
         if (mq.size() == 0 && ready_i && m_bub < CMAX) m_bub++;
         if (out_ok) void'(mq.pop_front());
         if (in_ok) mq.push_back('{ctrl_i, data_i});
      end
      if (mq.size() > 0) m_shown = mq[0].d;
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      valid_i = 1'b1;
      ready_i = 1'b1;
      flush   = 1'b0;
      ctrl_i  = 12'hFFF;
      data_i  = 32'hDEAD_BEEF;
      step();
      step();
      checks++;
      if (valid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%b exp=0", valid_o);
      end
      checks++;
      if (ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=1", ready_o);
      end
      checks++;
      if (ctrl_o !== '0 || data_o !== '0) begin
         failures++;
         $display("FAIL reset_payload ctrl=%h data=%h exp=0", ctrl_o, data_o);
      end
      checks++;
      if (occ !== 2'd0 || bub_cnt !== '0 || fl_cnt !== '0) begin
         failures++;
         $display("FAIL reset_counts occ=%0d bub=%0d fl=%0d exp=0",
                  occ, bub_cnt, fl_cnt);
      end
      rst_n   = 1'b1;
      valid_i = 1'b0;
   endtask

   task automatic test_streaming();
      valid_i = 1'b1;
      ready_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         ctrl_i = CW'(i);
         data_i = DW'(i);
         step();
         checks++;
         if (valid_o !== 1'b1 || occ !== 2'd1 || data_o !== DW'(i)
             || ctrl_o !== CW'(i)) begin
            failures++;
            $display("FAIL stream_%0d v=%b occ=%0d data=%0d ctrl=%0d exp=1/1/%0d/%0d",
                     i, valid_o, occ, data_o, ctrl_o, i, i);
         end
      end
      valid_i = 1'b0;
      step();
      checks++;
      if (valid_o !== 1'b0 || ctrl_o !== '0 || data_o !== DW'(8)) begin
         failures++;
         $display("FAIL stream_drain v=%b ctrl=%h data=%0d exp=0/0/8",
                  valid_o, ctrl_o, data_o);
      end
   endtask

   task automatic test_backpressure();
      ready_i = 1'b0;
      valid_i = 1'b1;
      ctrl_i  = 12'h0A1;
      data_i  = 32'hAAAA_0001;
      step();
      ctrl_i  = 12'h0B2;
      data_i  = 32'hBBBB_0002;
      step();
      checks++;
      if (occ !== 2'd2 || ready_o !== 1'b0 || data_o !== 32'hAAAA_0001) begin
         failures++;
         $display("FAIL bp_full occ=%0d rdy=%b data=%h exp=2/0/aaaa0001",
                  occ, ready_o, data_o);
      end
      valid_i = 1'b0;
      step();
      checks++;
      if (occ !== 2'd2 || data_o !== 32'hAAAA_0001 || ctrl_o !== 12'h0A1) begin
         failures++;
         $display("FAIL bp_hold occ=%0d data=%h ctrl=%h exp=2/aaaa0001/0a1",
                  occ, data_o, ctrl_o);
      end
      ready_i = 1'b1;
      step();
      checks++;
      if (occ !== 2'd1 || ready_o !== 1'b1 || data_o !== 32'hBBBB_0002
          || ctrl_o !== 12'h0B2) begin
         failures++;
         $display("FAIL bp_second occ=%0d rdy=%b data=%h ctrl=%h exp=1/1/bbbb0002/0b2",
                  occ, ready_o, data_o, ctrl_o);
      end
      step();
      checks++;
      if (occ !== 2'd0 || valid_o !== 1'b0) begin
         failures++;
         $display("FAIL bp_empty occ=%0d v=%b exp=0/0", occ, valid_o);
      end
   endtask

   task automatic test_flush();
      logic [NW-1:0] fl_before;
      ready_i = 1'b0;
      valid_i = 1'b1;
      ctrl_i  = 12'h0D1;
      data_i  = 32'hDDDD_0001;
      step();
      ctrl_i  = 12'h0E2;
      data_i  = 32'hEEEE_0002;
      step();
      fl_before = fl_cnt;
      flush   = 1'b1;
      ctrl_i  = 12'h0C3;
      data_i  = 32'hCCCC_0003;
      step();
      checks++;
      if (valid_o !== 1'b0 || ctrl_o !== '0 || occ !== 2'd0
          || data_o !== 32'hDDDD_0001) begin
         failures++;
         $display("FAIL flush_state v=%b ctrl=%h occ=%0d data=%h exp=0/0/0/dddd0001",
                  valid_o, ctrl_o, occ, data_o);
      end
      checks++;
      if (fl_cnt !== fl_before + NW'(1)) begin
         failures++;
         $display("FAIL flush_count got=%0d exp=%0d", fl_cnt, fl_before + NW'(1));
      end
      flush   = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (valid_o !== 1'b0 || data_o === 32'hCCCC_0003) begin
            failures++;
            $display("FAIL flush_ghost_%0d v=%b data=%h exp=0/not-cccc0003",
                     i, valid_o, data_o);
         end
      end
      fl_before = fl_cnt;
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (fl_cnt !== fl_before) begin
         failures++;
         $display("FAIL flush_empty_count got=%0d exp=%0d", fl_cnt, fl_before);
      end
   endtask

   task automatic test_reset_mid();
      ready_i = 1'b0;
      valid_i = 1'b1;
      ctrl_i  = 12'h111;
      data_i  = 32'h1111_1111;
      step();
      data_i  = 32'h2222_2222;
      step();
      checks++;
      if (occ !== 2'd2) begin
         failures++;
         $display("FAIL rstmid_fill occ=%0d exp=2", occ);
      end
      rst_n  = 1'b0;
      data_i = 32'h3333_3333;
      step();
      rst_n   = 1'b1;
      valid_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || occ !== 2'd0
          || ctrl_o !== '0 || data_o !== '0) begin
         failures++;
         $display("FAIL rstmid_outs v=%b r=%b occ=%0d ctrl=%h data=%h exp=0/1/0/0/0",
                  valid_o, ready_o, occ, ctrl_o, data_o);
      end
      checks++;
      if (bub_cnt !== '0 || fl_cnt !== '0) begin
         failures++;
         $display("FAIL rstmid_cnt bub=%0d fl=%0d exp=0/0", bub_cnt, fl_cnt);
      end
   endtask

   task automatic test_bubble_sat();
      valid_i = 1'b0;
      ready_i = 1'b1;
      flush   = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         checks++;
         if (int'(bub_cnt) != ((i < CMAX) ? i : CMAX)) begin
            failures++;
            $display("FAIL bubble_%0d got=%0d exp=%0d",
                     i, bub_cnt, (i < CMAX) ? i : CMAX);
         end
      end
   endtask

   task automatic test_random();
      logic [CW-1:0] exp_c;
      for (int n = 0; n < 600; n++) begin
         rst_n   = ($urandom_range(63) != 0);
         flush   = ($urandom_range(15) == 0);
         valid_i = ($urandom_range(3) != 0);
         ready_i = ($urandom_range(2) != 0);
         ctrl_i  = CW'($urandom);
         data_i  = $urandom;
         step();
         exp_c = (mq.size() > 0) ? mq[0].c : '0;
         checks++;
         if (valid_o !== (mq.size() > 0) || ready_o !== (mq.size() < 2)
             || int'(occ) != mq.size()) begin
            failures++;
            $display("FAIL rand_hs_%0d v=%b r=%b occ=%0d exp_occ=%0d",
                     n, valid_o, ready_o, occ, mq.size());
         end
         checks++;
         if (ctrl_o !== exp_c || data_o !== m_shown) begin
            failures++;
            $display("FAIL rand_payload_%0d ctrl=%h data=%h exp=%h/%h",
                     n, ctrl_o, data_o, exp_c, m_shown);
         end
         checks++;
         if (int'(bub_cnt) != m_bub || int'(fl_cnt) != m_fl) begin
            failures++;
            $display("FAIL rand_cnt_%0d bub=%0d fl=%0d exp=%0d/%0d",
                     n, bub_cnt, fl_cnt, m_bub, m_fl);
         end
      end
      rst_n = 1'b1;
      flush = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_shown  = '0;
      m_bub    = 0;
      m_fl     = 0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_bubble_sat();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pip_stage_skid.md
PIP_STAGE_SKID -- requirements
Module: pip_stage_skid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload bits (operands, PC, immediate) held but not cleared on flush.
REQ-002 SHALL have parameter CTRL_WIDTH, default 12: control bits (RegWrite, MemWrite, Jump, Branch, ...) forced to 0 on flush.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-004 SHALL have port clk_i, input, 1: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port valid_i, input, 1: upstream entry valid.
REQ-007 SHALL have port ready_o, output, 1: stage can accept an entry; registered.
REQ-008 SHALL have ports ctrl_i, input, CTRL_WIDTH, and data_i, input, DATA_WIDTH: upstream entry.
REQ-009 SHALL have port flush_i, input, 1: discard all held entries.
REQ-010 SHALL have port valid_o, output, 1: downstream entry valid.
REQ-011 SHALL have port ready_i, input, 1: downstream accepts.
REQ-012 SHALL have ports ctrl_o, output, CTRL_WIDTH, and data_o, output, DATA_WIDTH: downstream entry.
REQ-013 SHALL have port occupancy_o, output, 2: held entries, 0 to 2.
REQ-014 SHALL have ports bubble_cnt_o and flush_cnt_o, output, CNT_WIDTH each: statistics counters.

Function
REQ-015 SHALL hold two entries: main (drives ctrl_o/data_o) and skid; states EMPTY, ONE, TWO.
REQ-016 SHALL define input fire = valid_i && ready_o and output fire = valid_o && ready_i.
REQ-017 SHALL drive valid_o = (state != EMPTY) and ready_o = (state != TWO), both from registers, with no combinational path from ready_i or valid_i to any output.
REQ-018 SHALL give 1-cycle latency: an entry accepted at edge N appears on valid_o/ctrl_o/data_o after edge N when the stage was EMPTY, or ONE with output fire.
REQ-019 SHALL sustain one entry per cycle when valid_i and ready_i are held high.
REQ-020 SHALL, in EMPTY, on input fire: load main, go to ONE.
REQ-021 SHALL, in ONE, on input fire with output fire: load main, stay in ONE.
REQ-022 SHALL, in ONE, on input fire without output fire: load skid, go to TWO.
REQ-023 SHALL, in ONE, on output fire only: go to EMPTY.
REQ-024 SHALL, in TWO, on output fire: move skid to main, go to ONE; otherwise hold.
REQ-025 SHALL keep ctrl_o/data_o stable while valid_o=1 and ready_i=0.
REQ-026 SHALL preserve entry order; no entry is dropped or duplicated except by flush or reset.
REQ-027 SHALL, on flush_i=1 at an edge: go to EMPTY, set ctrl_o=0, hold data_o, and discard any simultaneous input fire; flush has priority over all handshakes.
REQ-028 SHALL drive ctrl_o=0 whenever in EMPTY.
REQ-029 SHALL increment bubble_cnt_o on each edge with valid_o=0, ready_i=1, flush_i=0, saturating at all-ones.
REQ-030 SHALL increment flush_cnt_o on each flush edge with occupancy_o>0, saturating at all-ones.
REQ-031 SHALL clear counters only on reset.

Reset
REQ-032 SHALL, on rst_n_i=0 at a rising edge, regardless of other inputs: go to EMPTY; valid_o=0, ready_o=1, ctrl_o=0, data_o=0, occupancy_o=0, bubble_cnt_o=0, flush_cnt_o=0.
REQ-033 SHALL discard held entries when reset is asserted mid-operation; no entry accepted in the reset cycle survives.

Verification
REQ-034 SHALL cover streaming: valid_i=1, ready_i=1, data_i=1,2,3,... -> data_o=1,2,3,... one cycle later, one per cycle, occupancy_o=1.
REQ-035 SHALL cover backpressure: ready_i=0 while sending A then B -> occupancy_o=2, ready_o=0, data_o=A held; release ready_i -> A then B out in order, ready_o=1 one cycle after A leaves.
REQ-036 SHALL cover flush with simultaneous input: occupancy 2 plus flush_i=1 and valid_i=1 with C -> next cycle valid_o=0, ctrl_o=0, occupancy_o=0, flush_cnt_o+1, C never appears.
REQ-037 SHALL cover reset mid-stream: rst_n_i=0 for one edge at occupancy 2 -> all outputs at reset values, counters 0.
REQ-038 SHALL cover bubble saturation: CNT_WIDTH=4, valid_i=0, ready_i=1 for 20 cycles -> bubble_cnt_o=15 and holds.
